// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: turns an EX/MEM memory op into a req/ack
// transaction, captures load data, stalls the pipeline while busy, halts on error.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [31:0] addrIn,
  input  logic [31:0] writeDataIn,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic [31:0] memDataOut,
  output logic        ppWrite,
  output logic        busError
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q;
  logic               req_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               access;

  assign access = validIn & (memReadIn | memWriteIn);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
            if (addrIn[1:0] == 2'b00) begin
              state_q <= S_WAIT;
              req_q   <= 1'b1;
              we_q    <= memWriteIn;
              addr_q  <= addrIn;
              wdata_q <= writeDataIn;
              cnt_q   <= '0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // An ack on the final allowed cycle takes priority over the timeout.
          if (memAck) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            if (!we_q) rdata_q <= memRData;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_ERR;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // EX/MEM still holds the finished instruction here, so never re-issue.
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ppWrite = 1'b1;
    case (state_q)
      S_IDLE:  ppWrite = ~access;
      S_WAIT:  ppWrite = 1'b0;
      S_ERR:   ppWrite = 1'b0;
      default: ppWrite = 1'b1;
    endcase
  end

  assign memReq     = req_q;
  assign memWe      = we_q;
  assign memAddr    = addr_q;
  assign memWData   = wdata_q;
  assign memDataOut = rdata_q;
  assign busError   = err_q;

endmodule
